// File: rtl/conv_pkg.sv
// Shared types and width helpers for the K x K convolution window engine.
// Pure declarations: no latency, no backpressure.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Index width able to address n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Zero-extended pixel times sign-extended weight, exact.
  function automatic int prod_width(input int ifm_w, input int wgt_w);
    return ifm_w + 1 + wgt_w;
  endfunction

  // Exact width of a sum of `taps` products.
  function automatic int sum_width(input int ifm_w, input int wgt_w, input int taps);
    return prod_width(ifm_w, wgt_w) + idx_width(taps);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Circular delay line of runtime length `len`; dout is the sample written `len` shifts ago.
// Read is combinational, write on en; no backpressure of its own (caller gates en).
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic             ptr_last;

  // Wrap at the runtime width so the delay equals exactly one image row.
  assign ptr_last = (LEN_W'(ptr) == len - LEN_W'(1));
  assign dout     = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      mem[ptr] <= din;
      ptr      <= ptr_last ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/conv_window_engine.sv
// Streaming K x K valid-convolution engine; one registered result 1 cycle after its completing pixel.
// ifm_ready drops while an unconsumed result is held; CONV_RELU_EN clamps results to [0, 2^(DATA_WIDTH-1)-1].
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_COLS     = 64,
  parameter int DIM_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wgt_valid,
  input  logic [WEIGHT_WIDTH-1:0] wgt_data,
  input  logic                    start,
  input  logic [DIM_WIDTH-1:0]    cfg_cols,
  input  logic [DIM_WIDTH-1:0]    cfg_rows,
  input  logic                    ifm_valid,
  input  logic [IFM_WIDTH-1:0]    ifm_data,
  output logic                    ifm_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WI_W = idx_width(TAPS);
`ifdef CONV_RELU_EN
  localparam int SUM_W = sum_width(IFM_WIDTH, WEIGHT_WIDTH, TAPS);
  localparam int ACC_W = (SUM_W > DATA_WIDTH) ? SUM_W : DATA_WIDTH;
`else
  // Wrapping output: modulo-2^DATA_WIDTH arithmetic throughout gives the same bits.
  localparam int ACC_W = DATA_WIDTH;
`endif
  localparam logic [DIM_WIDTH-1:0] K_D     = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [DIM_WIDTH-1:0] K1_D    = DIM_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [DIM_WIDTH-1:0] MAXC_D  = DIM_WIDTH'(MAX_COLS);
  localparam logic [WI_W-1:0]      WI_LAST = WI_W'(TAPS - 1);

  state_t                    state, state_nxt;
  logic                      done_nxt, err_nxt, start_go, cfg_ok;
  logic [WEIGHT_WIDTH-1:0]   weight [TAPS];
  logic [WI_W-1:0]           wgt_idx;
  logic                      wgt_loaded;
  logic [DIM_WIDTH-1:0]      cols_q, rows_q, col, row;
  logic [IFM_WIDTH-1:0]      win     [KERNEL_SIZE][KERNEL_SIZE];
  logic [IFM_WIDTH-1:0]      win_nxt [KERNEL_SIZE][KERNEL_SIZE];
  logic [IFM_WIDTH-1:0]      row_in  [KERNEL_SIZE];
  logic [IFM_WIDTH-1:0]      lb_out  [KERNEL_SIZE-1];
  logic                      pix_acc, win_full, col_last, last_pix;
  logic signed [ACC_W-1:0]   sum_full;
  logic [DATA_WIDTH-1:0]     result;

  function automatic logic signed [ACC_W-1:0] tap_mul(input logic [IFM_WIDTH-1:0] p,
                                                       input logic [WEIGHT_WIDTH-1:0] w);
    logic signed [ACC_W-1:0] pe, we;
    pe = $signed(ACC_W'(p));
    we = ACC_W'($signed(w));
    return pe * we;
  endfunction

  assign ifm_ready = (state == RUN) && (!out_valid || out_ready);
  assign pix_acc   = ifm_valid && ifm_ready;
  assign busy      = (state != IDLE);
  assign win_full  = (col >= K1_D) && (row >= K1_D);
  assign col_last  = (col == cols_q - DIM_WIDTH'(1));
  assign last_pix  = col_last && (row == rows_q - DIM_WIDTH'(1));
  assign cfg_ok    = wgt_loaded && (cfg_cols >= K_D) && (cfg_cols <= MAXC_D) && (cfg_rows >= K_D);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    start_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            start_go  = 1'b1;
            state_nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN:     if (pix_acc && last_pix) state_nxt = FLUSH;
      FLUSH: begin
        if (!out_valid || out_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      cfg_err <= err_nxt;
    end
  end

  // Weight loading; wgt_loaded is sampled by start before this edge updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_idx    <= '0;
      wgt_loaded <= 1'b0;
      for (int i = 0; i < TAPS; i++) weight[i] <= '0;
    end else if (state == IDLE && wgt_valid) begin
      weight[wgt_idx] <= wgt_data;
      if (wgt_idx == WI_LAST) begin
        wgt_idx    <= '0;
        wgt_loaded <= 1'b1;
      end else begin
        wgt_idx <= wgt_idx + WI_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q <= '0;
      rows_q <= '0;
      col    <= '0;
      row    <= '0;
    end else if (start_go) begin
      cols_q <= cfg_cols;
      rows_q <= cfg_rows;
      col    <= '0;
      row    <= '0;
    end else if (pix_acc) begin
      col <= col_last ? '0 : col + DIM_WIDTH'(1);
      row <= col_last ? row + DIM_WIDTH'(1) : row;
    end
  end

  for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_lb
    conv_line_buffer #(
      .DEPTH (MAX_COLS),
      .WIDTH (IFM_WIDTH),
      .LEN_W (DIM_WIDTH)
    ) u_lb (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_go),
      .en    (pix_acc),
      .len   (cols_q),
      .din   (row_in[g]),
      .dout  (lb_out[g])
    );
  end

  // Row 0 is the live pixel; row r comes r image rows earlier; column c is c pixels older.
  always_comb begin
    row_in[0] = ifm_data;
    for (int r = 1; r < KERNEL_SIZE; r++) row_in[r] = lb_out[r-1];
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      win_nxt[r][0] = row_in[r];
      for (int c = 1; c < KERNEL_SIZE; c++) win_nxt[r][c] = win[r][c-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++) win[r][c] <= '0;
    end else if (start_go) begin
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++) win[r][c] <= '0;
    end else if (pix_acc) begin
      win <= win_nxt;
    end
  end

  // weight[0] pairs with the top-left (oldest row, oldest column) pixel.
  always_comb begin
    sum_full = '0;
    for (int wr = 0; wr < KERNEL_SIZE; wr++)
      for (int wc = 0; wc < KERNEL_SIZE; wc++)
        sum_full = sum_full + tap_mul(win_nxt[KERNEL_SIZE-1-wr][KERNEL_SIZE-1-wc],
                                      weight[wr*KERNEL_SIZE + wc]);
  end

`ifdef CONV_RELU_EN
  localparam logic signed [ACC_W-1:0] POS_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  always_comb begin
    if (sum_full[ACC_W-1])        result = '0;
    else if (sum_full > POS_MAX)  result = POS_MAX[DATA_WIDTH-1:0];
    else                          result = sum_full[DATA_WIDTH-1:0];
  end
`else
  assign result = sum_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pix_acc && win_full) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Self-checking bench for conv_window_engine: directed patterns plus randomized frames
// compared against a direct 2-D convolution model.
module tb_conv_window_engine;

  localparam int K    = 3;
  localparam int KK   = K * K;
  localparam int MAXC = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wgt_valid = 1'b0, start = 1'b0, ifm_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  wgt_data = '0, cfg_cols = '0, cfg_rows = '0, ifm_data = '0;
  logic        ifm_ready, out_valid, busy, done, cfg_err;
  logic [15:0] out_data;

  int          errors = 0, checks = 0;
  int          img [0:1023];
  int          wts [0:KK-1];
  logic [15:0] got_q[$], exp_q[$];
  int          done_cnt, stall_err;
  logic [15:0] stall_first;

  conv_window_engine #(
    .KERNEL_SIZE(K), .IFM_WIDTH(8), .WEIGHT_WIDTH(8),
    .DATA_WIDTH(16), .MAX_COLS(MAXC), .DIM_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wgt_valid(wgt_valid), .wgt_data(wgt_data),
    .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .ifm_valid(ifm_valid), .ifm_data(ifm_data), .ifm_ready(ifm_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) img[i] = i + 1;
  endtask

  // Direct valid-mode 2-D correlation over the stored image.
  task automatic build_expected(input int cols, input int rows);
    int s;
    exp_q.delete();
    for (int r = K - 1; r < rows; r++)
      for (int c = K - 1; c < cols; c++) begin
        s = 0;
        for (int wr = 0; wr < K; wr++)
          for (int wc = 0; wc < K; wc++)
            s += wts[wr*K + wc] * img[(r-K+1+wr)*cols + (c-K+1+wc)];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
        if (s > 32767) s = 32767;
`endif
        exp_q.push_back(16'(s));
      end
  endtask

  task automatic load_weights(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wgt_valid = 1'b1;
      wgt_data  = 8'(wts[i]);
    end
    @(negedge clk);
    wgt_valid = 1'b0;
  endtask

  // mode 0: always ready; 1: random valid/ready; 2: stall 5 cycles on first result.
  task automatic run_frame(input int cols, input int rows, input int mode, output int tmo);
    int n, pix_i, post, stall_left, budget;
    bit stalled;
    n = cols * rows; pix_i = 0; post = 0; stall_left = 0; stalled = 0;
    budget = 40 * n + 100;
    got_q.delete(); done_cnt = 0; stall_err = 0; stall_first = 'x;
    @(negedge clk);
    cfg_cols = 8'(cols); cfg_rows = 8'(rows); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget && post < 4; cyc++) begin
      ifm_valid = (pix_i < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      ifm_data  = (pix_i < n) ? 8'(img[pix_i]) : 8'd0;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && !stalled && out_valid) begin
        stalled = 1; stall_left = 5; stall_first = out_data;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (mode == 2 && !out_ready &&
          (out_data !== stall_first || ifm_ready !== 1'b0 || out_valid !== 1'b1)) stall_err++;
      if (ifm_valid && ifm_ready) pix_i++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      @(negedge clk);
    end
    ifm_valid = 1'b0;
    out_ready = 1'b1;
    tmo = (post < 4) ? 1 : 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ifm_ready, out_valid, busy, done, cfg_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, expected 00000", {ifm_ready, out_valid, busy, done, cfg_err});
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got 0x%04h, expected 0x0000", out_data);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({ifm_ready, out_valid, busy, done, cfg_err, out_data} !== 21'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b, expected all zero", {ifm_ready, out_valid, busy, done, cfg_err, out_data});
    end
  endtask

  task automatic test_patterns();
    int tmo;
    string nm;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < KK; i++) wts[i] = (p == 0) ? 1 : (p == 1) ? ((i == 4) ? 1 : 0) : -1;
      fill_ramp(16);
      load_weights(KK);
      run_frame(4, 4, 0, tmo);
      case (p)
        0: begin nm = "ones";   exp_q = {16'd54, 16'd63, 16'd90, 16'd99}; end
        1: begin nm = "centre"; exp_q = {16'd6, 16'd7, 16'd10, 16'd11}; end
        default: begin
          nm = "negative";
`ifdef CONV_RELU_EN
          exp_q = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
          exp_q = {16'hFFCA, 16'hFFC1, 16'hFFA6, 16'hFF9D};
`endif
        end
      endcase
      checks++;
      if (tmo != 0) begin errors++; $display("FAIL %s_timeout: timeout=%0d, expected 0", nm, tmo); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL %s_count: got %0d results, expected %0d", nm, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL %s_data[%0d]: got 0x%04h, expected 0x%04h", nm, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s_done: pulses=%0d, expected 1", nm, done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int tmo;
    for (int i = 0; i < KK; i++) wts[i] = 1;
    fill_ramp(16);
    load_weights(KK);
    run_frame(4, 4, 2, tmo);
    exp_q = {16'd54, 16'd63, 16'd90, 16'd99};
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL bp_timeout: timeout=%0d, expected 0", tmo); end
    checks++;
    if (stall_first !== 16'd54) begin errors++; $display("FAIL bp_held_value: got 0x%04h, expected 0x0036", stall_first); end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: %0d unstable stall cycles, expected 0", stall_err); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_data[%0d]: got 0x%04h, expected 0x%04h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int tc [4] = '{2, 4, 65, 4};
    int tr [4] = '{4, 2, 4, 1};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      cfg_cols = 8'(tc[t]); cfg_rows = 8'(tr[t]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_reject_%0dx%0d: cfg_err=%b busy=%b, expected 1 0", tc[t], tr[t], cfg_err, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_pulse_%0dx%0d: cfg_err=%b busy=%b, expected 0 0", tc[t], tr[t], cfg_err, busy);
      end
    end
  endtask

  task automatic test_random();
    int tmo, cols, rows;
    for (int f = 0; f < 4; f++) begin
      cols = (f == 0) ? MAXC : (f == 1) ? 3 : int'($urandom_range(3, 12));
      rows = (f == 1) ? 3 : int'($urandom_range(3, 8));
      for (int i = 0; i < KK; i++) wts[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < cols * rows; i++) img[i] = int'($urandom_range(0, 255));
      build_expected(cols, rows);
      load_weights(KK);
      run_frame(cols, rows, 1, tmo);
      checks++;
      if (tmo != 0) begin errors++; $display("FAIL rnd%0d_timeout: timeout=%0d, expected 0", f, tmo); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_count: got %0d results, expected %0d", f, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_data[%0d]: got 0x%04h, expected 0x%04h", f, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done: pulses=%0d, expected 1", f, done_cnt); end
    end
  endtask

  task automatic test_reset_midframe();
    int n, tmo;
    for (int i = 0; i < KK; i++) wts[i] = 1;
    fill_ramp(16);
    load_weights(KK);
    @(negedge clk);
    cfg_cols = 8'd4; cfg_rows = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0;
    for (int cyc = 0; cyc < 50 && n < 7; cyc++) begin
      ifm_valid = 1'b1; ifm_data = 8'(img[n]); out_ready = 1'b1;
      #1;
      if (ifm_ready) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL midrst_feed: accepted %0d pixels, expected 7", n); end
    rst_n = 1'b0; ifm_valid = 1'b0;
    #1;
    checks++;
    if ({ifm_ready, out_valid, busy, done, cfg_err, out_data} !== 21'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b, expected all zero", {ifm_ready, out_valid, busy, done, cfg_err, out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_cols = 8'd4; cfg_rows = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_no_weights: cfg_err=%b busy=%b, expected 1 0", cfg_err, busy);
    end
    load_weights(KK);
    run_frame(4, 4, 0, tmo);
    exp_q = {16'd54, 16'd63, 16'd90, 16'd99};
    checks++;
    if (tmo != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_reload: timeout=%0d results=%0d, expected 0 %0d", tmo, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_data[%0d]: got 0x%04h, expected 0x%04h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wgt_start_same_cycle();
    int tmo;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < KK; i++) wts[i] = (i == KK - 1) ? 3 : 1;
    fill_ramp(16);
    load_weights(KK - 1);
    wgt_valid = 1'b1; wgt_data = 8'(wts[KK-1]);
    cfg_cols = 8'd4; cfg_rows = 8'd4; start = 1'b1;
    @(negedge clk);
    wgt_valid = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL same_cycle_reject: cfg_err=%b busy=%b, expected 1 0", cfg_err, busy);
    end
    build_expected(4, 4);
    run_frame(4, 4, 0, tmo);
    checks++;
    if (tmo != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL same_cycle_frame: timeout=%0d results=%0d, expected 0 %0d", tmo, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL same_cycle_data[%0d]: got 0x%04h, expected 0x%04h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_cfg_err();
    test_random();
    test_reset_midframe();
    test_wgt_start_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
